// File: rtl/axi4_mgr_fifo.sv
// First-word-fall-through data FIFO between the AXI4 manager and its data producer/consumer.
// Status flags decode from a registered level counter, so push_i/pop_i never reach an output combinationally.
module axi4_mgr_fifo #(
  parameter int DATA_WIDTH  = 64,
  parameter int DEPTH       = 16,
  parameter int AF_MARGIN   = 2,
  parameter int LEVEL_WIDTH = $clog2(DEPTH) + 1
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic                   clr_i,
  input  logic                   push_i,
  input  logic [DATA_WIDTH-1:0]  data_i,
  output logic                   ready_o,
  input  logic                   pop_i,
  output logic [DATA_WIDTH-1:0]  data_o,
  output logic                   empty_o,
  output logic                   full_o,
  output logic                   almost_full_o,
  output logic [LEVEL_WIDTH-1:0] level_o,
  output logic                   overflow_o,
  output logic                   underflow_o
);

  localparam int PTR_WIDTH = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0]  mem [DEPTH];
  logic [PTR_WIDTH-1:0]   wr_ptr;
  logic [PTR_WIDTH-1:0]   rd_ptr;
  logic [LEVEL_WIDTH-1:0] level;
  logic                   pop_acc;
  logic                   push_acc;

  assign empty_o       = (level == '0);
  assign full_o        = (level == LEVEL_WIDTH'(DEPTH));
  assign almost_full_o = (level >= LEVEL_WIDTH'(DEPTH - AF_MARGIN));
  assign ready_o       = !full_o;
  assign level_o       = level;
  assign data_o        = empty_o ? '0 : mem[rd_ptr];

  // A push into a full FIFO is legal when a pop frees the head slot in the same cycle.
  assign pop_acc  = pop_i && !empty_o;
  assign push_acc = push_i && (!full_o || pop_acc);

  always_ff @(posedge clk_i) begin
    if (push_acc && !clr_i) begin
      mem[wr_ptr] <= data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else if (clr_i) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      if (push_acc) begin
        wr_ptr <= wr_ptr + PTR_WIDTH'(1);
      end
      if (pop_acc) begin
        rd_ptr <= rd_ptr + PTR_WIDTH'(1);
      end
      case ({push_acc, pop_acc})
        2'b10:   level <= level + LEVEL_WIDTH'(1);
        2'b01:   level <= level - LEVEL_WIDTH'(1);
        default: level <= level;
      endcase
      if (push_i && full_o && !pop_acc) begin
        overflow_o <= 1'b1;
      end
      if (pop_i && empty_o) begin
        underflow_o <= 1'b1;
      end
    end
  end

endmodule

// File: doc/axi4_mgr_fifo.md
Name: axi4_mgr_fifo

Overview:
- Synchronous first-word-fall-through (FWFT) data FIFO. It buffers beats between the AXI4 manager and its data producer/consumer.
- Write path: a producer pushes words, the manager's W channel pops them.
  - Manager's wr_fifo_req pulse connects to pop_i.
  - data_o connects to the manager's wr_fifo_data input.
- Read path: the manager's R channel pushes words, a consumer pops them.
  - Manager's rd_fifo_gnt connects to push_i.
  - ready_o connects to the manager's rd_fifo_req input.
- One instance is used per direction.

Parameters:
- DATA_WIDTH, 64, word width; matches the manager's AXI data width.
- DEPTH, 16, number of entries; must be a power of 2 and at least 2.
- AF_MARGIN, 2, almost_full_o asserts when level >= DEPTH - AF_MARGIN; range 0..DEPTH-1.
- LEVEL_WIDTH, $clog2(DEPTH)+1, width of the level counter; derived, do not override.

Ports:
- clk_i  in  1  clock; all logic is on the rising edge.
- rstn_i  in  1  asynchronous active-low reset.
- clr_i  in  1  synchronous flush: empties the FIFO and clears the error flags.
- push_i  in  1  push strobe, one word per cycle.
- data_i  in  DATA_WIDTH  push data, sampled on an accepted push.
- ready_o  out  1  space available; equals !full_o.
- pop_i  in  1  pop strobe, one word per cycle.
- data_o  out  DATA_WIDTH  head word (FWFT); '0 when empty.
- empty_o  out  1  FIFO empty.
- full_o  out  1  FIFO full.
- almost_full_o  out  1  level >= DEPTH - AF_MARGIN.
- level_o  out  LEVEL_WIDTH  current occupancy, 0..DEPTH.
- overflow_o  out  1  sticky: a push was dropped.
- underflow_o  out  1  sticky: a pop was issued while empty.

Behaviour:
- Reset state (asynchronous, rstn_i=0):
  - wr_ptr=0, rd_ptr=0, level=0.
  - empty_o=1, full_o=0, ready_o=1, almost_full_o=0 (=1 if AF_MARGIN=DEPTH... not allowed).
  - data_o='0, overflow_o=0, underflow_o=0.
  - Storage array is not reset.
- Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- level_o is a registered counter:
  - push only: +1.
  - pop only: -1.
  - both accepted, or neither: unchanged.
- Flags are decoded from the registered level:
  - empty_o = (level==0).
  - full_o = (level==DEPTH).
  - almost_full_o = (level >= DEPTH-AF_MARGIN).
- Pop acceptance: pop_acc = pop_i && !empty_o. Effect: rd_ptr+1.
- Push acceptance: push_acc = push_i && (!full_o || pop_acc). Effect: mem[wr_ptr] <= data_i, then wr_ptr+1.
  - Push while full is accepted only if a pop is accepted in the same cycle.
- data_o:
  - Combinational: data_o = mem[rd_ptr] when !empty_o, else '0.
  - Changes only after a clock edge, never combinationally from pop_i.
- Latency: a word pushed at edge N is visible on data_o and empty_o=0 after edge N. There is no same-cycle bypass.
- Simultaneous push and pop while empty: the pop is rejected and sets underflow_o; the push is accepted; level becomes 1.
- Simultaneous push and pop while full: both are accepted; level stays at DEPTH; the new word goes into the slot freed by the pop.
- overflow_o set condition: push_i && full_o && !pop_acc. The dropped word leaves the FIFO state unchanged.
- underflow_o set condition: pop_i && empty_o. Pointers are unchanged.
- Both error flags are sticky until clr_i or reset.
- clr_i has priority over push_i and pop_i in the same cycle. On clr_i:
  - pointers and level go to 0.
  - both error flags go to 0.
  - push and pop in that cycle are ignored and do not set the flags.
- Reset mid-operation: immediate asynchronous return to the reset state; contents are discarded.
- No combinational paths from push_i/pop_i to any output.
- Intended usage with the manager:
  - The manager's pop strobe is asserted only while its W channel holds valid data.
  - On the read path, rd_fifo_req is tied to ready_o, so a well-formed system never sets overflow_o or underflow_o. Both flags exist for the bench and for debug.

Test Plan (DEPTH=4, AF_MARGIN=1, DATA_WIDTH=64 unless stated):
- Reset check: drive rstn_i=0 then release. Outputs: empty_o=1, full_o=0, ready_o=1, level_o=0, data_o=0, both error flags 0.
- Fill/drain: push 0xA0..0xA3 on 4 consecutive cycles.
  - level_o reads 1,2,3,4; almost_full_o rises at level 3; full_o=1 and ready_o=0 at level 4.
  - Pop 4 times: data_o reads 0xA0,0xA1,0xA2,0xA3 in order; then empty_o=1 and data_o=0.
- Overflow and full-boundary behaviour, starting full:
  - push 0xFF with no pop: overflow_o=1, level_o stays 4, head stays 0xA0.
  - push 0xB0 with pop in the same cycle: accepted, level_o=4, 0xB0 is read out last.
- Underflow when empty:
  - pop while empty: underflow_o=1, level_o=0.
  - push 0xC0 and pop in the same cycle: level_o=1, data_o=0xC0 on the next cycle.
- Wrap-around:
  - 10 cycles of push 0x100+i with a pop every cycle after the first: pointers wrap twice, every word is read back in order, level_o holds at 1.
- clr_i priority:
  - With 3 entries and both error flags set, assert clr_i together with push_i and pop_i.
  - Next cycle: level_o=0, empty_o=1, both error flags 0.
  - Assert rstn_i low mid-burst: all outputs return to reset values asynchronously.
